// File: rtl/wb_stage.sv
// Writeback stage: registers M-stage results, extracts/extends load data and
// drives the GRF write port. Define WB_RETIRE_CNT_EN to add the retire counter.
module wb_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        M_Valid,
    input  logic [31:0] M_PC,
    input  logic [31:0] M_ALU,
    input  logic [31:0] M_MemRD,
    input  logic [4:0]  M_WA,
    input  logic        M_RegWrite,
    input  logic [1:0]  M_WDSel,
    input  logic [2:0]  M_LoadType,
    input  logic [1:0]  M_ByteOff,
`ifdef WB_RETIRE_CNT_EN
    output logic [31:0] retire_cnt,
`endif
    output logic [31:0] W_PC,
    output logic [4:0]  W_WA,
    output logic        W_WE,
    output logic [31:0] W_WD,
    output logic        W_Valid
);

    logic        valid_q;
    logic [31:0] pc_q;
    logic [31:0] alu_q;
    logic [31:0] memrd_q;
    logic [4:0]  wa_q;
    logic        regwrite_q;
    logic [1:0]  wdsel_q;
    logic [2:0]  loadtype_q;
    logic [1:0]  byteoff_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            pc_q       <= RESET_PC;
            alu_q      <= 32'd0;
            memrd_q    <= 32'd0;
            wa_q       <= 5'd0;
            regwrite_q <= 1'b0;
            wdsel_q    <= 2'd0;
            loadtype_q <= 3'd0;
            byteoff_q  <= 2'd0;
        end else if (flush) begin
            // Bubble keeps the incoming PC so trace output stays meaningful.
            valid_q    <= 1'b0;
            pc_q       <= M_PC;
            alu_q      <= 32'd0;
            memrd_q    <= 32'd0;
            wa_q       <= 5'd0;
            regwrite_q <= 1'b0;
            wdsel_q    <= 2'd0;
            loadtype_q <= 3'd0;
            byteoff_q  <= 2'd0;
        end else if (!stall) begin
            valid_q    <= M_Valid;
            pc_q       <= M_PC;
            alu_q      <= M_ALU;
            memrd_q    <= M_MemRD;
            wa_q       <= M_WA;
            regwrite_q <= M_RegWrite;
            wdsel_q    <= M_WDSel;
            loadtype_q <= M_LoadType;
            byteoff_q  <= M_ByteOff;
        end
    end

    logic [31:0] shifted_d;
    logic [7:0]  byte_d;
    logic [15:0] half_d;
    logic [31:0] load_d;
    logic [31:0] wd_d;

    always_comb begin
        shifted_d = memrd_q >> {byteoff_q, 3'b000};
        byte_d    = shifted_d[7:0];
        half_d    = byteoff_q[1] ? memrd_q[31:16] : memrd_q[15:0];
        case (loadtype_q)
            3'd1:    load_d = {{24{byte_d[7]}}, byte_d};
            3'd2:    load_d = {24'd0, byte_d};
            3'd3:    load_d = {{16{half_d[15]}}, half_d};
            3'd4:    load_d = {16'd0, half_d};
            default: load_d = memrd_q;
        endcase
    end

    always_comb begin
        wd_d = alu_q;
        case (wdsel_q)
            2'd1:    wd_d = load_d;
            2'd2:    wd_d = pc_q + 32'd8;
            default: wd_d = alu_q;
        endcase
        if (!valid_q) begin
            wd_d = 32'd0;
        end
    end

    assign W_PC    = pc_q;
    assign W_WA    = wa_q;
    assign W_WE    = regwrite_q & valid_q & (wa_q != 5'd0);
    assign W_WD    = wd_d;
    assign W_Valid = valid_q;

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt_q;
    logic [31:0] retire_cnt_d;

    // A held instruction counts only on the edge it leaves W.
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (valid_q && !stall) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt_q <= 32'd0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage: reset, load extension, link, $0 write,
// stall/flush priority and (when WB_RETIRE_CNT_EN is defined) retire counting.
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        M_Valid;
    logic [31:0] M_PC;
    logic [31:0] M_ALU;
    logic [31:0] M_MemRD;
    logic [4:0]  M_WA;
    logic        M_RegWrite;
    logic [1:0]  M_WDSel;
    logic [2:0]  M_LoadType;
    logic [1:0]  M_ByteOff;
    logic [31:0] W_PC;
    logic [4:0]  W_WA;
    logic        W_WE;
    logic [31:0] W_WD;
    logic        W_Valid;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    int checks = 0;
    int errors = 0;

    wb_stage #(.RESET_PC(32'h0000_3000)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .M_Valid    (M_Valid),
        .M_PC       (M_PC),
        .M_ALU      (M_ALU),
        .M_MemRD    (M_MemRD),
        .M_WA       (M_WA),
        .M_RegWrite (M_RegWrite),
        .M_WDSel    (M_WDSel),
        .M_LoadType (M_LoadType),
        .M_ByteOff  (M_ByteOff),
`ifdef WB_RETIRE_CNT_EN
        .retire_cnt (retire_cnt),
`endif
        .W_PC       (W_PC),
        .W_WA       (W_WA),
        .W_WE       (W_WE),
        .W_WD       (W_WD),
        .W_Valid    (W_Valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_m(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] rd, input logic [4:0] wa, input logic rw,
                         input logic [1:0] sel, input logic [2:0] lt, input logic [1:0] off);
        M_Valid = v; M_PC = pc; M_ALU = alu; M_MemRD = rd; M_WA = wa;
        M_RegWrite = rw; M_WDSel = sel; M_LoadType = lt; M_ByteOff = off;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (W_PC !== 32'h0000_3000 || W_WA !== 5'd0 || W_WE !== 1'b0 ||
            W_WD !== 32'd0 || W_Valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: pc=%h wa=%0d we=%b wd=%h v=%b required pc=00003000 wa=0 we=0 wd=0 v=0",
                     W_PC, W_WA, W_WE, W_WD, W_Valid);
        end
        $display("reset: pc=%h we=%b wd=%h", W_PC, W_WE, W_WD);
    endtask

    task automatic test_load_ext();
        logic [2:0]  lt_tab  [8] = '{3'd1, 3'd2, 3'd1, 3'd3, 3'd4, 3'd7, 3'd3, 3'd0};
        logic [1:0]  off_tab [8] = '{2'd3, 2'd3, 2'd1, 2'd2, 2'd0, 2'd0, 2'd3, 2'd1};
        logic [31:0] exp_tab [8] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_007F,
                                     32'hFFFF_80F1, 32'h0000_7F02, 32'h80F1_7F02,
                                     32'hFFFF_80F1, 32'h80F1_7F02};
        for (int i = 0; i < 8; i++) begin
            set_m(1'b1, 32'h0000_3100, 32'hDEAD_BEEF, 32'h80F1_7F02, 5'd3, 1'b1, 2'd1,
                  lt_tab[i], off_tab[i]);
            tick();
            checks++;
            if (W_WD !== exp_tab[i] || W_WE !== 1'b1) begin
                errors++;
                $display("FAIL load_ext[%0d]: wd=%h we=%b required wd=%h we=1",
                         i, W_WD, W_WE, exp_tab[i]);
            end
            $display("load lt=%0d off=%0d wd=%h", lt_tab[i], off_tab[i], W_WD);
        end
    endtask

    task automatic test_link();
        set_m(1'b1, 32'h0000_3010, 32'h1111_1111, 32'h2222_2222, 5'd31, 1'b1, 2'd2, 3'd0, 2'd0);
        tick();
        checks++;
        if (W_WD !== 32'h0000_3018 || W_WE !== 1'b1 || W_WA !== 5'd31 || W_PC !== 32'h0000_3010) begin
            errors++;
            $display("FAIL link: wd=%h we=%b wa=%0d pc=%h required wd=00003018 we=1 wa=31 pc=00003010",
                     W_WD, W_WE, W_WA, W_PC);
        end
        $display("link pc=%h wd=%h", W_PC, W_WD);
        set_m(1'b1, 32'hFFFF_FFFC, 32'h1111_1111, 32'h2222_2222, 5'd31, 1'b1, 2'd2, 3'd0, 2'd0);
        tick();
        checks++;
        if (W_WD !== 32'h0000_0004) begin
            errors++;
            $display("FAIL link_wrap: wd=%h required 00000004", W_WD);
        end
        $display("link pc=%h wd=%h", W_PC, W_WD);
    endtask

    task automatic test_zero_write();
        set_m(1'b1, 32'h0000_3020, 32'h1234_5678, 32'h0, 5'd0, 1'b1, 2'd0, 3'd0, 2'd0);
        tick();
        checks++;
        if (W_WE !== 1'b0 || W_WA !== 5'd0 || W_WD !== 32'h1234_5678) begin
            errors++;
            $display("FAIL zero_write: we=%b wa=%0d wd=%h required we=0 wa=0 wd=12345678",
                     W_WE, W_WA, W_WD);
        end
        $display("zero_write we=%b wd=%h", W_WE, W_WD);
        set_m(1'b1, 32'h0000_3024, 32'hCAFE_0001, 32'h5555_5555, 5'd7, 1'b0, 2'd3, 3'd0, 2'd0);
        tick();
        checks++;
        if (W_WD !== 32'hCAFE_0001 || W_WE !== 1'b0 || W_WA !== 5'd7) begin
            errors++;
            $display("FAIL sel3_norw: wd=%h we=%b wa=%0d required wd=cafe0001 we=0 wa=7",
                     W_WD, W_WE, W_WA);
        end
        $display("sel3 wd=%h we=%b", W_WD, W_WE);
    endtask

    task automatic test_stall_flush();
        set_m(1'b1, 32'h0000_3030, 32'd1, 32'h0, 5'd2, 1'b1, 2'd0, 3'd0, 2'd0);
        tick();
        checks++;
        if (W_WD !== 32'd1 || W_WE !== 1'b1 || W_PC !== 32'h0000_3030) begin
            errors++;
            $display("FAIL capture_a: wd=%h we=%b pc=%h required wd=1 we=1 pc=00003030", W_WD, W_WE, W_PC);
        end
        set_m(1'b1, 32'h0000_3034, 32'd2, 32'h0, 5'd4, 1'b1, 2'd0, 3'd0, 2'd0);
        stall = 1'b1;
        tick();
        checks++;
        if (W_WD !== 32'd1 || W_WA !== 5'd2 || W_PC !== 32'h0000_3030 || W_Valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold: wd=%h wa=%0d pc=%h v=%b required wd=1 wa=2 pc=00003030 v=1",
                     W_WD, W_WA, W_PC, W_Valid);
        end
        $display("stall hold wd=%h", W_WD);
        M_PC = 32'h0000_4000;
        M_WDSel = 2'd2;
        flush = 1'b1;
        tick();
        checks++;
        if (W_Valid !== 1'b0 || W_WE !== 1'b0 || W_WD !== 32'd0 || W_WA !== 5'd0 ||
            W_PC !== 32'h0000_4000) begin
            errors++;
            $display("FAIL flush_wins: v=%b we=%b wd=%h wa=%0d pc=%h required v=0 we=0 wd=0 wa=0 pc=00004000",
                     W_Valid, W_WE, W_WD, W_WA, W_PC);
        end
        $display("flush bubble v=%b pc=%h", W_Valid, W_PC);
        stall = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_reset_midstream();
        set_m(1'b1, 32'h0000_3050, 32'h0000_AAAA, 32'h0, 5'd5, 1'b1, 2'd0, 3'd0, 2'd0);
        tick();
        checks++;
        if (W_WE !== 1'b1 || W_WA !== 5'd5 || W_WD !== 32'h0000_AAAA) begin
            errors++;
            $display("FAIL pre_reset: we=%b wa=%0d wd=%h required we=1 wa=5 wd=0000aaaa", W_WE, W_WA, W_WD);
        end
        #2;
        stall = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if (W_WE !== 1'b0 || W_WA !== 5'd0 || W_WD !== 32'd0 || W_PC !== 32'h0000_3000 || W_Valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: we=%b wa=%0d wd=%h pc=%h v=%b required we=0 wa=0 wd=0 pc=00003000 v=0",
                     W_WE, W_WA, W_WD, W_PC, W_Valid);
        end
        $display("async reset pc=%h we=%b", W_PC, W_WE);
        tick();
        #2;
        rst = 1'b0;
        stall = 1'b0;
        tick();
        checks++;
        if (W_WE !== 1'b1 || W_WA !== 5'd5 || W_PC !== 32'h0000_3050) begin
            errors++;
            $display("FAIL post_reset_capture: we=%b wa=%0d pc=%h required we=1 wa=5 pc=00003050",
                     W_WE, W_WA, W_PC);
        end
        $display("post reset capture pc=%h", W_PC);
    endtask

`ifdef WB_RETIRE_CNT_EN
    task automatic test_retire();
        rst = 1'b1;
        set_m(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0, 3'd0, 2'd0);
        #1;
        rst = 1'b0;
        set_m(1'b1, 32'h0000_3100, 32'd1, 32'h0, 5'd1, 1'b1, 2'd0, 3'd0, 2'd0);
        tick();
        set_m(1'b1, 32'h0000_3104, 32'd2, 32'h0, 5'd2, 1'b1, 2'd0, 3'd0, 2'd0);
        tick();
        stall = 1'b1;
        tick();
        tick();
        stall = 1'b0;
        set_m(1'b0, 32'h0000_3108, 32'd0, 32'h0, 5'd0, 1'b0, 2'd0, 3'd0, 2'd0);
        tick();
        set_m(1'b1, 32'h0000_310C, 32'd3, 32'h0, 5'd3, 1'b1, 2'd0, 3'd0, 2'd0);
        tick();
        set_m(1'b0, 32'h0000_3110, 32'd0, 32'h0, 5'd0, 1'b0, 2'd0, 3'd0, 2'd0);
        tick();
        tick();
        checks++;
        if (retire_cnt !== 32'd3) begin
            errors++;
            $display("FAIL retire_cnt: got %0d required 3", retire_cnt);
        end
        $display("retire_cnt=%0d", retire_cnt);
    endtask
`endif

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        set_m(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0, 3'd0, 2'd0);
        #1;
        test_reset();
        #11;
        rst = 1'b0;
        test_load_ext();
        test_link();
        test_zero_write();
        test_stall_flush();
        test_reset_midstream();
`ifdef WB_RETIRE_CNT_EN
        test_retire();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback (W) stage of the 5-stage MIPS pipeline. Registers the M-stage results at the M/W boundary.
- Performs load-data extraction and extension, and selects the writeback source.
- Drives the register file's write address, write enable, write data and trace PC.
- Sits directly upstream of the GRF write port. Its outputs connect to GRF WA/WE/WD/PC without further logic.

Parameters:
- RESET_PC, 32'h0000_3000, value loaded into W_PC on reset.

Ports:
- clk  input  1  pipeline clock, rising edge active
- rst  input  1  asynchronous, active-high reset
- stall  input  1  hold the W register contents this cycle
- flush  input  1  replace the captured instruction with a bubble
- M_Valid  input  1  M-stage slot holds a real instruction
- M_PC  input  32  M-stage instruction PC
- M_ALU  input  32  ALU result
- M_MemRD  input  32  raw word read from the data memory, aligned word
- M_WA  input  5  destination register
- M_RegWrite  input  1  instruction writes the GRF
- M_WDSel  input  2  writeback source: 0 = ALU, 1 = memory, 2 = PC+8, 3 = reserved (ALU)
- M_LoadType  input  3  0 = lw, 1 = lb, 2 = lbu, 3 = lh, 4 = lhu, others = lw
- M_ByteOff  input  2  address bits [1:0] of the access
- W_PC  output  32  PC of the instruction in W
- W_WA  output  5  GRF write address
- W_WE  output  1  GRF write enable
- W_WD  output  32  GRF write data
- W_Valid  output  1  W slot holds a real instruction
- retire_cnt  output  32  present only with WB_RETIRE_CNT_EN

Behaviour:
- Reset (rst = 1, asynchronous, takes effect immediately without a clock edge):
  - W_PC = RESET_PC.
  - All other W registers cleared: W_WA = 0, W_WE = 0, W_WD = 0, W_Valid = 0.
- Capture rule at each rising edge of clk, in priority order:
  - flush = 1: load a bubble (Valid = 0, RegWrite = 0, WA = 0, data = 0, PC = M_PC).
  - else stall = 1: hold all registers.
  - else: capture every M_* input.
- Simultaneous flush and stall: flush wins.
- Latency:
  - One cycle from the M inputs to the W outputs.
  - W_WD is combinational from the registered fields only, with no combinational path from M_* to any W output.
- W_WE = registered RegWrite AND registered Valid AND (registered WA != 0).
  - WA = 0 never asserts W_WE.
  - W_WA still reflects the captured value.
- Load extraction, on registered MemRD word w and offset off:
  - lb / lbu: byte = w[8*off+7 : 8*off]. lb sign-extends to 32 bits; lbu zero-extends.
  - lh / lhu: half = off[1] ? w[31:16] : w[15:0]. off[0] is ignored (misalignment is trapped upstream). lh sign-extends; lhu zero-extends.
  - lw and any undefined LoadType: w unchanged.
- Writeback source:
  - WDSel 0: ALU.
  - WDSel 1: extracted load data.
  - WDSel 2: captured PC + 32'd8. Addition is modulo 2^32, so 32'hFFFF_FFFC gives 32'h0000_0004.
  - WDSel 3: ALU.
- Bubble (Valid = 0): W_WD = 0 regardless of WDSel.
- Stall during reset: reset dominates.
- Deassertion of rst: the first capture happens on the next rising edge.

Optional Feature:
- WB_RETIRE_CNT_EN defined:
  - 32-bit counter retire_cnt, asynchronously reset to 0.
  - Increments by 1 on every rising edge where the W slot holds Valid = 1 and stall = 0.
  - Counts each instruction once, even if it is held for several cycles. Wraps at 2^32 - 1 to 0.
  - Port retire_cnt exists.
- Not defined: no counter logic and no retire_cnt port. All other behaviour is identical.

Test Plan:
- Reset mid-stream:
  - Stimulus: capture a valid write to $5; assert rst between clock edges.
  - Response: W_WE = 0, W_WA = 0, W_WD = 0 and W_PC = 32'h0000_3000 immediately, before the next edge.
- Load extension:
  - Stimulus: M_MemRD = 32'h80F1_7F02, WDSel = 1.
  - Response: lb off = 3 gives FFFF_FF80; lbu off = 3 gives 0000_0080; lb off = 1 gives 0000_007F; lh off = 2 gives FFFF_80F1; lhu off = 0 gives 0000_7F02; LoadType = 7 gives 80F1_7F02.
- PC+8 link:
  - Stimulus: M_PC = 32'h0000_3010, WDSel = 2, WA = 31.
  - Response: W_WD = 32'h0000_3018, W_WE = 1. With M_PC = FFFF_FFFC, W_WD = 0000_0004.
- $0 write:
  - Stimulus: RegWrite = 1, WA = 0, ALU = 32'h1234_5678.
  - Response: W_WE = 0.
- Stall/flush priority:
  - Stimulus: capture A (ALU = 1); next edge stall = 1 with input B; next edge stall = flush = 1.
  - Response: A held for one cycle; then bubble with W_Valid = 0, W_WE = 0, W_WD = 0.
- Retire counter (WB_RETIRE_CNT_EN):
  - Stimulus: 3 valid instructions, one of them stalled for 2 cycles, plus 1 bubble.
  - Response: retire_cnt = 3.
